// File: rtl/mips_alu_pkg.sv
// Shared ALU opcode, MIPS opcode/funct constants and the issue record used by mips_alu_issue.
package mips_alu_pkg;

    localparam logic [3:0] ALU_OP_ADD = 4'd0;
    localparam logic [3:0] ALU_OP_SUB = 4'd1;
    localparam logic [3:0] ALU_OP_AND = 4'd2;
    localparam logic [3:0] ALU_OP_OR  = 4'd3;
    localparam logic [3:0] ALU_OP_XOR = 4'd4;
    localparam logic [3:0] ALU_OP_LUI = 4'd5;
    localparam logic [3:0] ALU_OP_SLL = 4'd6;
    localparam logic [3:0] ALU_OP_SRL = 4'd7;
    localparam logic [3:0] ALU_OP_SRA = 4'd8;

    localparam logic [5:0] OPC_RTYPE = 6'h00;
    localparam logic [5:0] OPC_BEQ   = 6'h04;
    localparam logic [5:0] OPC_BNE   = 6'h05;
    localparam logic [5:0] OPC_ADDI  = 6'h08;
    localparam logic [5:0] OPC_ADDIU = 6'h09;
    localparam logic [5:0] OPC_ANDI  = 6'h0C;
    localparam logic [5:0] OPC_ORI   = 6'h0D;
    localparam logic [5:0] OPC_XORI  = 6'h0E;
    localparam logic [5:0] OPC_LUI   = 6'h0F;
    localparam logic [5:0] OPC_LW    = 6'h23;
    localparam logic [5:0] OPC_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        is_branch;
        logic        branch_ne;
        logic        illegal;
    } alu_issue_t;

endpackage

// File: rtl/mips_alu_op_decode.sv
// Combinational MIPS opcode/funct decode into ALU opcode and selected/extended operands.
module mips_alu_op_decode
    import mips_alu_pkg::*;
(
    input  logic [5:0]  opcode_i,
    input  logic [5:0]  funct_i,
    input  logic [4:0]  shamt_i,
    input  logic [15:0] imm_i,
    input  logic [31:0] rs_val_i,
    input  logic [31:0] rt_val_i,
    output alu_issue_t  issue_o
);

    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    assign imm_sext = {{16{imm_i[15]}}, imm_i};
    assign imm_zext = {16'b0, imm_i};

    // Unknown encodings fall out of the default: ADD of zeros flagged illegal.
    always_comb begin
        issue_o         = '0;
        issue_o.op      = ALU_OP_ADD;
        issue_o.illegal = 1'b1;
        case (opcode_i)
            OPC_RTYPE: begin
                case (funct_i)
                    FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR: begin
                        issue_o.illegal = 1'b0;
                        issue_o.a       = rs_val_i;
                        issue_o.b       = rt_val_i;
                        case (funct_i)
                            FN_SUB, FN_SUBU: issue_o.op = ALU_OP_SUB;
                            FN_AND:          issue_o.op = ALU_OP_AND;
                            FN_OR:           issue_o.op = ALU_OP_OR;
                            FN_XOR:          issue_o.op = ALU_OP_XOR;
                            default:         issue_o.op = ALU_OP_ADD;
                        endcase
                    end
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                        issue_o.illegal = 1'b0;
                        issue_o.a       = rt_val_i;
                        issue_o.b       = funct_i[2] ? {27'b0, rs_val_i[4:0]} : {27'b0, shamt_i};
                        case (funct_i[1:0])
                            2'b10:   issue_o.op = ALU_OP_SRL;
                            2'b11:   issue_o.op = ALU_OP_SRA;
                            default: issue_o.op = ALU_OP_SLL;
                        endcase
                    end
                    default: ;
                endcase
            end
            OPC_ADDI, OPC_ADDIU, OPC_LW, OPC_SW: begin
                issue_o.illegal = 1'b0;
                issue_o.a       = rs_val_i;
                issue_o.b       = imm_sext;
            end
            OPC_ANDI, OPC_ORI, OPC_XORI: begin
                issue_o.illegal = 1'b0;
                issue_o.a       = rs_val_i;
                issue_o.b       = imm_zext;
                case (opcode_i)
                    OPC_ANDI: issue_o.op = ALU_OP_AND;
                    OPC_ORI:  issue_o.op = ALU_OP_OR;
                    default:  issue_o.op = ALU_OP_XOR;
                endcase
            end
            OPC_LUI: begin
                issue_o.illegal = 1'b0;
                issue_o.op      = ALU_OP_LUI;
                issue_o.a       = {imm_i, 16'b0};
            end
            OPC_BEQ, OPC_BNE: begin
                issue_o.illegal   = 1'b0;
                issue_o.op        = ALU_OP_SUB;
                issue_o.a         = rs_val_i;
                issue_o.b         = rt_val_i;
                issue_o.is_branch = 1'b1;
                issue_o.branch_ne = opcode_i[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mips_alu_issue.sv
// ID/EX issue stage: decodes into an ALU request and registers it behind valid/ready.
// Optional 1-entry skid buffer selected by MIPS_ALU_ISSUE_SKID_EN.
module mips_alu_issue
    import mips_alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OP_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [5:0]        in_opcode,
    input  logic [5:0]        in_funct,
    input  logic [4:0]        in_shamt,
    input  logic [15:0]       in_imm,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   out_alu_op,
    output logic [DATA_W-1:0] out_a,
    output logic [DATA_W-1:0] out_b,
    output logic              out_is_branch,
    output logic              out_branch_ne,
    output logic              out_illegal
);

    alu_issue_t dec;
    alu_issue_t out_q, out_d;
    logic       out_valid_q, out_valid_d;
    logic       accept;
    logic       drain;

    mips_alu_op_decode u_decode (
        .opcode_i (in_opcode),
        .funct_i  (in_funct),
        .shamt_i  (in_shamt),
        .imm_i    (in_imm),
        .rs_val_i (in_rs_val),
        .rt_val_i (in_rt_val),
        .issue_o  (dec)
    );

    assign drain  = !out_valid_q || out_ready;
    assign accept = in_valid && in_ready;

`ifdef MIPS_ALU_ISSUE_SKID_EN
    alu_issue_t skid_q, skid_d;
    logic       skid_valid_q, skid_valid_d;

    assign in_ready = !rst && !skid_valid_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            // Skid always drains first so beat order is preserved.
            if (drain) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_d       = dec;
                skid_valid_d = accept;
            end
        end else if (accept) begin
            if (drain) begin
                out_d       = dec;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = !rst && drain;

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = dec;
            out_valid_d = 1'b1;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_alu_op    = out_q.op;
    assign out_a         = out_q.a;
    assign out_b         = out_q.b;
    assign out_is_branch = out_q.is_branch;
    assign out_branch_ne = out_q.branch_ne;
    assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_mips_alu_issue.sv
// Self-checking bench for mips_alu_issue: vector table, stall/flush/reset sequences, random traffic.
module tb_mips_alu_issue;

`ifdef MIPS_ALU_ISSUE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk, rst, flush, in_valid, in_ready, out_valid, out_ready;
    logic [5:0]  in_opcode, in_funct;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [31:0] in_rs_val, in_rt_val, out_a, out_b;
    logic [3:0]  out_alu_op;
    logic        out_is_branch, out_branch_ne, out_illegal;

    mips_alu_issue #(.DATA_W(32), .OP_W(4)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_funct(in_funct), .in_shamt(in_shamt), .in_imm(in_imm),
        .in_rs_val(in_rs_val), .in_rt_val(in_rt_val),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_alu_op(out_alu_op), .out_a(out_a), .out_b(out_b),
        .out_is_branch(out_is_branch), .out_branch_ne(out_branch_ne), .out_illegal(out_illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        br, ne, ill;
    } exp_t;

    typedef struct {
        logic [5:0]  opc, fn;
        logic [4:0]  sh;
        logic [15:0] imm;
        logic [31:0] rs, rt;
        logic [3:0]  op;
        logic [31:0] a, b;
        logic        br, ne, ill;
    } vec_t;

    exp_t q[$];
    int   total = 0;
    int   bad = 0;
    bit   zeroed;
    bit   last_acc, last_oxfer;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference decode written straight from the instruction table.
    function automatic exp_t ref_decode(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                                        input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        exp_t e;
        int   f, o;
        e = '{op: 4'd0, a: 32'd0, b: 32'd0, br: 1'b0, ne: 1'b0, ill: 1'b1};
        f = int'(fn);
        o = int'(opc);
        if (o == 0) begin
            if (f >= 'h20 && f <= 'h26) begin
                e.ill = 1'b0; e.a = rs; e.b = rt;
                e.op = (f <= 'h21) ? 4'd0 : (f <= 'h23) ? 4'd1 : 4'(f - 'h22);
            end else if (f == 0 || f == 2 || f == 3) begin
                e.ill = 1'b0; e.a = rt; e.b = 32'(sh);
                e.op = (f == 0) ? 4'd6 : 4'(f + 5);
            end else if (f == 4 || f == 6 || f == 7) begin
                e.ill = 1'b0; e.a = rt; e.b = rs % 32;
                e.op = (f == 4) ? 4'd6 : 4'(f + 1);
            end
        end else if (o == 'h08 || o == 'h09 || o == 'h23 || o == 'h2B) begin
            e.ill = 1'b0; e.a = rs;
            e.b = (imm >= 16'h8000) ? 32'hFFFF0000 + 32'(imm) : 32'(imm);
        end else if (o >= 'h0C && o <= 'h0E) begin
            e.ill = 1'b0; e.a = rs; e.b = 32'(imm); e.op = 4'(o - 'h0C + 2);
        end else if (o == 'h0F) begin
            e.ill = 1'b0; e.op = 4'd5; e.a = 32'(imm) * 65536;
        end else if (o == 4 || o == 5) begin
            e.ill = 1'b0; e.op = 4'd1; e.a = rs; e.b = rt; e.br = 1'b1; e.ne = (o == 5);
        end
        return e;
    endfunction

    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("op", 32'(out_alu_op), 32'(q[0].op));
            chk("a", out_a, q[0].a);
            chk("b", out_b, q[0].b);
            chk("flags", {29'd0, out_is_branch, out_branch_ne, out_illegal}, {29'd0, q[0].br, q[0].ne, q[0].ill});
        end else if (zeroed) begin
            chk("rst_fields", {28'd0, out_alu_op} | out_a | out_b | {29'd0, out_is_branch, out_branch_ne, out_illegal}, 32'd0);
        end
    endtask

    // Called just after a falling edge with inputs already driven; returns after the next falling edge.
    task automatic cycle();
        bit er;
        #1;
        if (rst) er = 1'b0;
        else if (SKID) er = (q.size() < 2);
        else er = (q.size() == 0) || out_ready;
        chk("in_ready", 32'(in_ready), 32'(er));
        last_acc   = in_valid && in_ready;
        last_oxfer = out_valid && out_ready;
        if (rst) begin
            q.delete();
            zeroed = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            if (out_ready && q.size() != 0) void'(q.pop_front());
            if (in_valid && er) begin
                q.push_back(ref_decode(in_opcode, in_funct, in_shamt, in_imm, in_rs_val, in_rt_val));
                zeroed = 1'b0;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic set_instr(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                             input logic [15:0] imm, input logic [31:0] rs, input logic [31:0] rt);
        in_opcode = opc; in_funct = fn; in_shamt = sh; in_imm = imm; in_rs_val = rs; in_rt_val = rt;
    endtask

    task automatic rand_instr();
        logic [5:0] opcs [12];
        logic [5:0] fns [13];
        opcs = '{6'h00, 6'h00, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
        fns  = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26};
        set_instr(($urandom_range(0, 7) == 0) ? 6'($urandom) : opcs[$urandom_range(0, 11)],
                  ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 12)],
                  5'($urandom), 16'($urandom), $urandom, $urandom);
    endtask

    vec_t vecs [16];
    int   stall_acc, oxf, idx;

    initial begin
        vecs[0]  = '{6'h00, 6'h20, 5'd0,  16'h0000, 32'd5,        32'd7,        4'd0, 32'd5,        32'd7,        1'b0, 1'b0, 1'b0};
        vecs[1]  = '{6'h08, 6'h00, 5'd0,  16'hFFFF, 32'd0,        32'd0,        4'd0, 32'd0,        32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{6'h0F, 6'h00, 5'd0,  16'h1234, 32'h55,       32'h66,       4'd5, 32'h12340000, 32'd0,        1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'h00, 6'h03, 5'd4,  16'h0000, 32'h11,       32'h80000000, 4'd8, 32'h80000000, 32'd4,        1'b0, 1'b0, 1'b0};
        vecs[4]  = '{6'h00, 6'h07, 5'd0,  16'h0000, 32'h25,       32'h1234,     4'd8, 32'h1234,     32'd5,        1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'h05, 6'h00, 5'd0,  16'h0000, 32'd3,        32'd3,        4'd1, 32'd3,        32'd3,        1'b1, 1'b1, 1'b0};
        vecs[6]  = '{6'h3F, 6'h00, 5'd0,  16'hABCD, 32'd1,        32'd2,        4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[7]  = '{6'h00, 6'h22, 5'd0,  16'h0000, 32'd10,       32'd3,        4'd1, 32'd10,       32'd3,        1'b0, 1'b0, 1'b0};
        vecs[8]  = '{6'h00, 6'h24, 5'd0,  16'h0000, 32'hF0F0,     32'hFF00,     4'd2, 32'hF0F0,     32'hFF00,     1'b0, 1'b0, 1'b0};
        vecs[9]  = '{6'h0D, 6'h00, 5'd0,  16'h8000, 32'd1,        32'd9,        4'd3, 32'd1,        32'h00008000, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{6'h23, 6'h00, 5'd0,  16'h8000, 32'd100,      32'd9,        4'd0, 32'd100,      32'hFFFF8000, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{6'h04, 6'h00, 5'd0,  16'h0000, 32'd9,        32'd8,        4'd1, 32'd9,        32'd8,        1'b1, 1'b0, 1'b0};
        vecs[12] = '{6'h00, 6'h3F, 5'd0,  16'h0000, 32'd1,        32'd2,        4'd0, 32'd0,        32'd0,        1'b0, 1'b0, 1'b1};
        vecs[13] = '{6'h00, 6'h04, 5'd0,  16'h0000, 32'h21,       32'hF,        4'd6, 32'hF,        32'd1,        1'b0, 1'b0, 1'b0};
        vecs[14] = '{6'h00, 6'h02, 5'd31, 16'h0000, 32'd0,        32'hFFFFFFFF, 4'd7, 32'hFFFFFFFF, 32'd31,       1'b0, 1'b0, 1'b0};
        vecs[15] = '{6'h0E, 6'h00, 5'd0,  16'hFFFF, 32'd7,        32'd0,        4'd4, 32'd7,        32'h0000FFFF, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; zeroed = 1'b1;
        set_instr(6'h00, 6'h20, 5'd0, 16'h0, 32'd1, 32'd2);
        @(negedge clk);
        in_valid = 1'b1;
        cycle();
        cycle();
        rst = 1'b0; in_valid = 1'b0;
        cycle();

        // Vector table: each beat must appear one cycle after acceptance.
        for (int i = 0; i < 16; i++) begin
            set_instr(vecs[i].opc, vecs[i].fn, vecs[i].sh, vecs[i].imm, vecs[i].rs, vecs[i].rt);
            in_valid = 1'b1; out_ready = 1'b1;
            cycle();
            chk("vec_valid", 32'(out_valid), 32'd1);
            chk("vec_op", 32'(out_alu_op), 32'(vecs[i].op));
            chk("vec_a", out_a, vecs[i].a);
            chk("vec_b", out_b, vecs[i].b);
            chk("vec_flags", {29'd0, out_is_branch, out_branch_ne, out_illegal},
                {29'd0, vecs[i].br, vecs[i].ne, vecs[i].ill});
            in_valid = 1'b0;
            cycle();
        end

        // Stall for three cycles while streaming four beats.
        idx = 0; stall_acc = 0; oxf = 0;
        for (int c = 0; c < 12; c++) begin
            out_ready = (c >= 3);
            in_valid  = (idx < 4);
            set_instr(6'h00, 6'h20, 5'd0, 16'h0, 32'(100 + idx), 32'(idx));
            cycle();
            if (last_acc) begin
                idx++;
                if (c < 3) stall_acc++;
            end
            if (last_oxfer) oxf++;
        end
        chk("stall_absorbed", 32'(stall_acc), SKID ? 32'd2 : 32'd1);
        chk("stall_delivered", 32'(oxf), 32'd4);

        // Flush while stalled (skid full when present); beat offered in flush cycle is dropped.
        out_ready = 1'b0; in_valid = 1'b1;
        rand_instr(); cycle();
        rand_instr(); cycle();
        flush = 1'b1; rand_instr();
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        cycle();

        // Same, with reset instead of flush.
        in_valid = 1'b1;
        rand_instr(); cycle();
        rand_instr(); cycle();
        rst = 1'b1; rand_instr();
        cycle();
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_op", 32'(out_alu_op), 32'd0);
        chk("rst_a", out_a, 32'd0);
        chk("rst_b", out_b, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        cycle();

        // Random traffic against the queue model.
        for (int c = 0; c < 800; c++) begin
            rst       = ($urandom_range(0, 59) == 0);
            flush     = ($urandom_range(0, 24) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            rand_instr();
            cycle();
        end
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 3; c++) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
